game_cmd_sequencer: RTL
=======================

Name: game_cmd_sequencer

Overview:
- Upstream feeder for the Game block.
- Accepts a stream of ASCII move characters ('N','E','S','W') over a valid/ready handshake and buffers them in a small FIFO.
- Issues one decoded move at a time to the game, waiting for the game's step completion before issuing the next move.
- Reports sequence completion, bad characters and stalled steps.
- Replaces ad-hoc bench driving of direction strings with a synthesizable command path.

Parameters:
- DEPTH, 4: FIFO entries (power of two, at least 2).
- TIMEOUT, 64: cycles to wait for step_done after a move handshake before declaring a stall.
- CNT_W, 16: width of the completed-move counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command character valid.
- cmd_ready  out  1  sequencer can accept a character.
- cmd_char  in  8  ASCII move character.
- cmd_last  in  1  marks final character of a sequence.
- move_valid  out  1  move offered to game.
- move_ready  in  1  game accepts move.
- move_dir  out  2  decoded direction, dir_t.
- move_last  out  1  move is the last of its sequence.
- step_done  in  1  one-cycle pulse from game: accepted move finished.
- seq_done  out  1  one-cycle pulse: sequence fully executed.
- err_bad_char  out  1  one-cycle pulse: unrecognised character consumed.
- err_timeout  out  1  one-cycle pulse: step_done not seen within TIMEOUT.
- moves_cnt  out  CNT_W  saturating count of completed moves.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async assert, sync release): every output is 0, FIFO is empty, FSM is IDLE, counters are 0. Exception: cmd_ready is 1 after release.
- Input handshake: a character transfers when cmd_valid && cmd_ready. cmd_ready = !fifo_full, combinational from the occupancy count.
- Decode: 'N'=0, 'E'=1, 'S'=2, 'W'=3, uppercase only.
  - Any other character is consumed, and err_bad_char pulses the cycle after the handshake.
  - An invalid character is pushed only if cmd_last=1, as a NOP entry, so seq_done still fires. Otherwise nothing is pushed.
- FIFO entry: {last, nop, dir}, 4 bits, show-ahead.
  - Push and pop in the same cycle are legal at any occupancy, including full (pop frees the slot; push is still gated by cmd_ready seen that cycle).
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head into the hold register.
    - nop=1: if last, pulse seq_done next cycle; stay IDLE.
    - nop=0: go to ISSUE.
  - ISSUE: move_valid=1. move_dir and move_last come from the hold register and are stable until move_ready. When move_valid && move_ready, go to WAIT and clear the timer.
  - WAIT: timer increments each cycle.
    - step_done: moves_cnt++ (saturate at all-ones). If last, pulse seq_done. Go to IDLE.
    - timer reaching TIMEOUT-1 without step_done: pulse err_timeout, drop the move (no count), and pulse seq_done if last. Go to IDLE.
    - step_done in the same cycle as the timeout: step_done wins, no error.
  - step_done outside WAIT is ignored.
- Latency:
  - Handshake at cycle 0 → entry visible cycle 1 → popped cycle 1 → move_valid cycle 2.
  - Back-to-back: step_done at cycle t with a non-empty FIFO → IDLE pop at t+1 → move_valid at t+2.
- Only one move is in flight at a time.
- Reset mid-operation flushes the FIFO and in-flight move with no pulses; the game side sees move_valid fall asynchronously.

Decomposition:
- game_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_N, DIR_E, DIR_S, DIR_W};
  - ASCII constants CH_N/E/S/W;
  - the packed struct cmd_entry_t {last, nop, dir};
  - the FSM state enum.
- One sub-module, game_cmd_fifo: parameterised DEPTH, show-ahead, push/pop/full/empty. The decode, FSM, timer and counter live in the top.

Test Plan:
- "ESE" with cmd_last on the final 'E', move_ready=1, step_done 3 cycles after each accept → move_dir 1,2,1; move_last only on the third; seq_done one cycle after the third step_done; moves_cnt=3.
- Same sequence with move_ready held low 10 cycles on the second move → move_valid high throughout, move_dir stays 2, no err_timeout (timer starts only after handshake).
- DEPTH=4, game stalled (move_ready=0), 6 characters offered back to back:
  - 5 are accepted (one popped into the hold register, 4 in the FIFO);
  - then cmd_ready=0 until move_ready goes high.
- "EXS": err_bad_char pulses once, moves issued are 1 then 2. 'X' with cmd_last → no move_valid, seq_done pulses, moves_cnt unchanged.
- TIMEOUT=16, "EN" with no step_done for the first move:
  - err_timeout pulses 16 cycles after the first handshake;
  - 'N' issues 2 cycles later;
  - step_done on the same cycle as the timeout (rerun) → no error, count increments.
- Assert rst_n low while in WAIT with 2 entries queued → outputs 0 immediately, after release busy=0, cmd_ready=1, moves_cnt=0, and a new "W" executes normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game command path: move directions, FIFO entry layout,
// sequencer states and the ASCII move decoder.
package game_pkg;

   typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;

   localparam logic [7:0] CH_N = 8'h4E;
   localparam logic [7:0] CH_E = 8'h45;
   localparam logic [7:0] CH_S = 8'h53;
   localparam logic [7:0] CH_W = 8'h57;

   // nop marks an entry with no move that only carries a sequence end
   typedef struct packed {
      logic last;
      logic nop;
      dir_t dir;
   } cmd_entry_t;

   localparam int ENTRY_W = $bits(cmd_entry_t);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} seq_state_t;

   // Returns {recognised, dir}; only uppercase N/E/S/W are moves.
   function automatic logic [2:0] decode_char(input logic [7:0] ch);
      logic [2:0] res;
      res = 3'b000;
      case (ch)
         CH_N:    res = {1'b1, DIR_N};
         CH_E:    res = {1'b1, DIR_E};
         CH_S:    res = {1'b1, DIR_S};
         CH_W:    res = {1'b1, DIR_W};
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/game_cmd_fifo.sv
// Show-ahead command FIFO; the head entry is visible on rdata whenever not empty.
module game_cmd_fifo
   import game_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic               pop,
   output logic [ENTRY_W-1:0] rdata,
   output logic               full,
   output logic               empty
);

   localparam int PW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW:0]        count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/game_cmd_sequencer.sv
// Turns a stream of N/E/S/W characters into one-at-a-time moves for the game,
// waiting for step completion and flagging bad characters and stalled steps.
module game_cmd_sequencer
   import game_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_char,
   input  logic             cmd_last,
   output logic             move_valid,
   input  logic             move_ready,
   output logic [1:0]       move_dir,
   output logic             move_last,
   input  logic             step_done,
   output logic             seq_done,
   output logic             err_bad_char,
   output logic             err_timeout,
   output logic [CNT_W-1:0] moves_cnt,
   output logic             busy
);

   localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT - 1);

   seq_state_t         state;
   seq_state_t         state_next;
   cmd_entry_t         hold;
   cmd_entry_t         head;
   cmd_entry_t         wentry;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [2:0]         dec;
   logic               char_ok;
   dir_t               char_dir;
   logic               cmd_fire;
   logic [TW-1:0]      timer;
   logic               load_hold;
   logic               timer_clr;
   logic               step_count;
   logic               seq_set;

   // Both channels transfer on a cycle where valid && ready; a producer holds
   // its payload stable while valid is high and ready is low.
   assign cmd_ready = !fifo_full;
   assign cmd_fire  = cmd_valid && cmd_ready;

   assign dec      = decode_char(cmd_char);
   assign char_ok  = dec[2];
   assign char_dir = dir_t'(dec[1:0]);

   // A bad character only occupies a slot when it ends a sequence
   assign fifo_push = cmd_fire && (char_ok || cmd_last);
   assign wentry    = {cmd_last, !char_ok, (char_ok ? char_dir : DIR_N)};

   game_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (wentry),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head = fifo_rdata;

   always_comb begin
      state_next  = state;
      fifo_pop    = 1'b0;
      load_hold   = 1'b0;
      timer_clr   = 1'b0;
      step_count  = 1'b0;
      seq_set     = 1'b0;
      err_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               load_hold = 1'b1;
               if (head.nop) seq_set    = head.last;
               else          state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (move_ready) begin
               state_next = ST_WAIT;
               timer_clr  = 1'b1;
            end
         end
         ST_WAIT: begin
            // step_done takes priority over a coincident timeout
            if (step_done) begin
               step_count = 1'b1;
               seq_set    = hold.last;
               state_next = ST_IDLE;
            end else if (timer == TIMER_END) begin
               err_timeout = 1'b1;
               seq_set     = hold.last;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         hold         <= '0;
         timer        <= '0;
         moves_cnt    <= '0;
         seq_done     <= 1'b0;
         err_bad_char <= 1'b0;
      end else begin
         state <= state_next;
         if (load_hold) hold <= head;
         if (timer_clr)              timer <= '0;
         else if (state == ST_WAIT)  timer <= timer + 1'b1;
         if (step_count && (moves_cnt != '1)) moves_cnt <= moves_cnt + 1'b1;
         seq_done     <= seq_set;
         err_bad_char <= cmd_fire && !char_ok;
      end
   end

   assign move_valid = (state == ST_ISSUE);
   assign move_dir   = move_valid ? hold.dir : 2'b00;
   assign move_last  = move_valid && hold.last;
   assign busy       = !fifo_empty || (state != ST_IDLE);

endmodule
